// File: rtl/divider_rr_scheduler.sv
// divider_rr_scheduler
//   Repetitive-subtraction divider shared by two requesters through a
//   round-robin arbiter. One subtraction per clock and one division in
//   flight. Each result comes back on a single response port, tagged with
//   the ID of the requester that issued it.
//
//   State table:
//     state | meaning
//     IDLE  | no operation; arbitrate and accept a request
//     SUB   | subtract the divisor from the remainder once per cycle
//     DONE  | result presented; wait for resp_ready
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req{0,1}_valid/_ready      request handshake per requester
//   req{0,1}_dividend/_divisor request operands
//   resp_valid/resp_ready      response handshake
//   resp_id                    requester that owns the result
//   quotient, remainder        result
//   div_by_zero                divisor was zero
//   busy                       state is not IDLE
module divider_rr_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_dividend,
    input  logic [WIDTH-1:0] req0_divisor,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_dividend,
    input  logic [WIDTH-1:0] req1_divisor,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic             dbz_q, dbz_d;

    logic             sel;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;    // port 0 wins the first tie
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            id_q    <= id_d;
            last_q  <= last_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        id_d    = id_q;
        last_d  = last_q;
        dbz_d   = dbz_q;

        // A tie goes to the port not granted last; a lone requester always wins.
        req0_ready = (state_q == IDLE) && req0_valid && (!req1_valid || last_q);
        req1_ready = (state_q == IDLE) && req1_valid && (!req0_valid || !last_q);

        sel          = req1_ready;
        sel_dividend = sel ? req1_dividend : req0_dividend;
        sel_divisor  = sel ? req1_divisor  : req0_divisor;

        case (state_q)
            IDLE: begin
                if (req0_ready || req1_ready) begin
                    rem_d  = sel_dividend;
                    dvs_d  = sel_divisor;
                    id_d   = sel;
                    last_d = sel;
                    if (sel_divisor == '0) begin
                        quo_d   = '1;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        quo_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = SUB;
                    end
                end
            end
            SUB: begin
                if (rem_q >= dvs_q) begin
                    rem_d = rem_q - dvs_q;
                    quo_d = quo_q + WIDTH'(1);
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_valid  = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign resp_id     = id_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/divider_rr_scheduler.md
Name: divider_rr_scheduler

Overview:
- Sequential repetitive-subtraction divider shared between two requesters through a round-robin arbiter.
- Requests use a valid/ready handshake; results return on a single response port tagged with the requester ID, with backpressure.
- Sits between arithmetic clients and the subtraction datapath. One subtraction per clock; one division in flight at a time.

Parameters:
- WIDTH, 8, bit width of dividend, divisor, quotient and remainder.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_dividend  input  WIDTH  requester 0 dividend.
- req0_divisor  input  WIDTH  requester 0 divisor.
- req1_valid  input  1  requester 1 has an operation.
- req1_ready  output  1  requester 1 operation accepted this cycle.
- req1_dividend  input  WIDTH  requester 1 dividend.
- req1_divisor  input  WIDTH  requester 1 divisor.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer takes the result.
- resp_id  output  1  requester that issued this result.
- quotient  output  WIDTH  result quotient.
- remainder  output  WIDTH  result remainder.
- div_by_zero  output  1  divisor was 0.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; resp_valid=0, resp_id=0, quotient=0, remainder=0, div_by_zero=0, busy=0.
  - last_grant=1, so port 0 wins the first tie.
  - Reset mid-operation abandons the division; no response is produced.
- States: IDLE, SUB, DONE.
- IDLE arbitration (combinational):
  - req0_ready = IDLE & req0_valid & (!req1_valid | last_grant==1).
  - req1_ready = IDLE & req1_valid & (!req0_valid | last_grant==0).
  - At most one ready high. Both are low outside IDLE.
- Acceptance edge (valid&ready):
  - Latch dividend into the remainder register, divisor into the divisor register, winner into resp_id and last_grant. Clear quotient.
  - If divisor==0: go to DONE with quotient=all ones, remainder=dividend, div_by_zero=1.
  - Otherwise: go to SUB with div_by_zero=0.
- SUB, each cycle:
  - If remainder>=divisor: remainder-=divisor, quotient+=1, stay in SUB.
  - Otherwise: go to DONE.
  - Compare and subtract are unsigned, WIDTH bits. Quotient cannot overflow because quotient<=dividend<=2^WIDTH-1.
- Latency: resp_valid rises Q+2 edges after the acceptance edge (Q = true quotient); for divide-by-zero, 1 edge. Worst case for WIDTH=8 (255/1) is 257 edges.
- DONE:
  - resp_valid=1.
  - quotient, remainder, resp_id and div_by_zero are held stable until the edge where resp_valid&resp_ready, then go to IDLE.
  - resp_valid deasserts on that same edge.
  - The next acceptance is possible at the earliest one edge after the response handshake (no same-edge turnaround).
- Outputs hold their last values in IDLE; they are valid only while resp_valid=1.
- Request inputs are sampled only on the acceptance edge. Changes afterwards do not affect the operation in flight.
- A requester held off by arbitration must keep valid and data stable. The block does not buffer it.
- Round-robin: a tie goes to the port not granted last. A lone requester always wins regardless of last_grant.

Test Plan:
- Port 0 only, 20/4 -> accepted in IDLE; resp_valid 7 edges later with quotient=5, remainder=0, resp_id=0, div_by_zero=0; busy high throughout.
- Both valid in the same cycle after reset: port0 15/6, port1 25/5 -> port 0 first (q=2, r=3, id=0). After the response, port 1 (q=5, r=0, id=1). A following tie, port0 18/3 vs port1 7/2 -> port 0 wins (last_grant=1): q=6, r=0, id=0.
- Port 1 issues 9/0 -> resp_valid 1 edge after acceptance; div_by_zero=1, quotient=255, remainder=9.
- 255/1 with resp_ready=0 for 10 cycles after resp_valid -> quotient=255, remainder=0 appears 257 edges after acceptance and is held stable until resp_ready=1; a new request is not accepted during DONE.
- Edge cases 3/7 -> q=0, r=3 after 2 edges; 7/7 -> q=1, r=0 after 3 edges.
- Assert rst_n low for 1 cycle mid-SUB of 200/1 -> all outputs 0 immediately (asynchronous); no stale response. A next request, 20/4 from port 0, completes normally (q=5, r=0) and wins a tie.
